// File: rtl/rx_pkg.sv
// rx_pkg: shared state, encodings, constants and the RATE lookup used by the
// 802.11a receive sequencer (rx_sequencer) and its SIGNAL parser.
package rx_pkg;

  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;
  localparam int SIG_BITS     = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIG_FEED,
    ST_SIG_WAIT,
    ST_SIG_CHECK,
    ST_DATA_FEED,
    ST_DATA_DRAIN,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'b00,
    MOD_QPSK  = 2'b01,
    MOD_16QAM = 2'b10,
    MOD_64QAM = 2'b11
  } mod_e;

  typedef enum logic [1:0] {
    CR_1_2 = 2'b00,
    CR_2_3 = 2'b01,
    CR_3_4 = 2'b10
  } cr_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_RATE    = 2'b01,
    ERR_PARITY  = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  typedef struct packed {
    logic       ok;
    mod_e       mod;
    cr_e        cr;
    logic [7:0] ndbps;
  } rate_info_t;

  // RATE field {b0,b1,b2,b3} -> modulation, code rate, data bits per symbol.
  function automatic rate_info_t rate_lookup(input logic [3:0] rate);
    rate_info_t info;
    case (rate)
      4'b1101: info = '{1'b1, MOD_BPSK,  CR_1_2, 8'd24};
      4'b1111: info = '{1'b1, MOD_BPSK,  CR_3_4, 8'd36};
      4'b0101: info = '{1'b1, MOD_QPSK,  CR_1_2, 8'd48};
      4'b0111: info = '{1'b1, MOD_QPSK,  CR_3_4, 8'd72};
      4'b1001: info = '{1'b1, MOD_16QAM, CR_1_2, 8'd96};
      4'b1011: info = '{1'b1, MOD_16QAM, CR_3_4, 8'd144};
      4'b0001: info = '{1'b1, MOD_64QAM, CR_2_3, 8'd192};
      4'b0011: info = '{1'b1, MOD_64QAM, CR_3_4, 8'd216};
      default: info = '{1'b0, MOD_BPSK,  CR_1_2, 8'd0};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/rx_signal_parser.sv
// rx_signal_parser: collects the 24 decoded SIGNAL bits (b0 first) and decodes
// RATE, LENGTH and the header sanity checks (parity, reserved, tail).
// hdr_ok is always produced; rx_sequencer only acts on it when
// RX_SIGNAL_PARITY_CHECK_EN is defined.
module rx_signal_parser
  import rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic        rate_ok,
  output mod_e        mod,
  output cr_e         cr,
  output logic [7:0]  ndbps,
  output logic [11:0] length,
  output logic        hdr_ok
);

  logic [SIG_BITS-1:0] sig_reg;
  logic [3:0]          rate;
  rate_info_t          info;

  // Shift right so that after 24 beats sig_reg[i] holds SIGNAL bit b_i.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of block ordering.
    if (rst || clr) begin
      sig_reg <= '0;
    end else if (shift_en) begin
      sig_reg <= {bit_in, sig_reg[SIG_BITS-1:1]};
    end
  end

  assign rate    = {sig_reg[0], sig_reg[1], sig_reg[2], sig_reg[3]};
  assign info    = rate_lookup(rate);
  assign rate_ok = info.ok;
  assign mod     = info.mod;
  assign cr      = info.cr;
  assign ndbps   = info.ndbps;
  assign length  = sig_reg[16:5];

  // Even parity over b0..b17, reserved b4 clear, tail b18..b23 clear.
  assign hdr_ok  = ~(^sig_reg[17:0]) & ~sig_reg[4]
                 & ~(|sig_reg[SIG_BITS-1 -: TAIL_BITS]);

endmodule

// File: rtl/rx_sequencer.sv
// rx_sequencer: packet-level controller for the 802.11a receive chain.
// Feeds the SIGNAL symbol at BPSK 1/2, decodes RATE/LENGTH, meters just
// enough DATA symbols into the chain and forwards only the PSDU bits.
// Optional: define RX_SIGNAL_PARITY_CHECK_EN to reject SIGNAL fields with bad
// parity, a set reserved bit or non-zero tail (err_code 10).
module rx_sequencer
  import rx_pkg::*;
#(
  parameter int SYM_GAP       = 200,
  parameter int SIG_TIMEOUT   = 1024,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [51:0] sym_in,
  input  logic        sym_valid,
  output logic        sym_ready,
  output logic [51:0] dp_in,
  output logic        dp_run,
  output logic [1:0]  dp_mod,
  output logic [1:0]  dp_cr,
  output logic        dp_clr,
  input  logic        sig_bit,
  input  logic        sig_bit_valid,
  input  logic        rx_bit,
  input  logic        rx_bit_valid,
  output logic        pld_bit,
  output logic        pld_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [15:0] GAP_L      = 16'(SYM_GAP);
  localparam logic [15:0] SIG_TO_L   = 16'(SIG_TIMEOUT - 1);
  localparam logic [15:0] DRAIN_TO_L = 16'(DRAIN_TIMEOUT - 1);
  localparam logic [15:0] SERVICE_L  = 16'(SERVICE_BITS);
  localparam logic [4:0]  SIG_LAST   = 5'(SIG_BITS - 1);

  state_e      state;
  // 16 bits because 22 + 8*4095 does not fit in 15.
  logic [15:0] need;
  logic [15:0] acc;
  logic [15:0] acc_next;
  logic [15:0] psdu_bits;
  logic [15:0] gap_cnt;
  logic [15:0] timer;
  logic [15:0] beat_cnt;
  logic [4:0]  bit_cnt;
  logic        accept;
  logic        start;
  logic        in_payload;

  logic        rate_ok;
  logic        hdr_ok;
  mod_e        mod;
  cr_e         cr;
  logic [7:0]  ndbps;
  logic [11:0] length;

  assign sym_ready  = (state == ST_SIG_FEED) ||
                      ((state == ST_DATA_FEED) && (gap_cnt >= GAP_L));
  assign accept     = sym_valid & sym_ready;
  assign start      = (state == ST_IDLE) & sym_valid;
  assign acc_next   = acc + {8'd0, ndbps};
  assign in_payload = (beat_cnt >= SERVICE_L) && (beat_cnt < SERVICE_L + psdu_bits);
  assign pld_valid  = (state == ST_DATA_DRAIN) & rx_bit_valid & in_payload;
  assign pld_bit    = pld_valid & rx_bit;
  assign busy       = (state != ST_IDLE);

`ifndef RX_SIGNAL_PARITY_CHECK_EN
  logic unused_hdr_ok;
  assign unused_hdr_ok = hdr_ok;
`endif

  rx_signal_parser u_parser (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .shift_en ((state == ST_SIG_WAIT) & sig_bit_valid),
    .bit_in   (sig_bit),
    .rate_ok  (rate_ok),
    .mod      (mod),
    .cr       (cr),
    .ndbps    (ndbps),
    .length   (length),
    .hdr_ok   (hdr_ok)
  );

  // Packet FSM with registered chain controls, pulses and error code.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: dp_in is a wide datapath register but it is an output that must
      // read zero out of reset, so it is reset along with the control state.
      state     <= ST_IDLE;
      dp_in     <= '0;
      dp_run    <= 1'b0;
      dp_mod    <= MOD_BPSK;
      dp_cr     <= CR_1_2;
      dp_clr    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      need      <= '0;
      acc       <= '0;
      psdu_bits <= '0;
      gap_cnt   <= '0;
      timer     <= '0;
      beat_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      dp_run <= 1'b0;
      dp_clr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      // Clocks since the last dp_run, saturating once the gap is satisfied.
      if (gap_cnt != GAP_L) gap_cnt <= gap_cnt + 16'd1;

      case (state)
        ST_IDLE: begin
          if (sym_valid) begin
            dp_clr   <= 1'b1;
            dp_mod   <= MOD_BPSK;
            dp_cr    <= CR_1_2;
            err_code <= ERR_NONE;
            state    <= ST_SIG_FEED;
          end
        end

        ST_SIG_FEED: begin
          if (accept) begin
            dp_in   <= sym_in;
            dp_run  <= 1'b1;
            gap_cnt <= '0;
            timer   <= '0;
            bit_cnt <= '0;
            state   <= ST_SIG_WAIT;
          end
        end

        ST_SIG_WAIT: begin
          if (sig_bit_valid) bit_cnt <= bit_cnt + 5'd1;
          if (sig_bit_valid && (bit_cnt == SIG_LAST)) begin
            state <= ST_SIG_CHECK;
          end else if (timer == SIG_TO_L) begin
            state    <= ST_ERROR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ST_SIG_CHECK: begin
          if (!rate_ok || (length == 12'd0)) begin
            state    <= ST_ERROR;
            err      <= 1'b1;
            err_code <= ERR_RATE;
          end
`ifdef RX_SIGNAL_PARITY_CHECK_EN
          else if (!hdr_ok) begin
            state    <= ST_ERROR;
            err      <= 1'b1;
            err_code <= ERR_PARITY;
          end
`endif
          else begin
            dp_mod    <= mod;
            dp_cr     <= cr;
            need      <= 16'd22 + {1'b0, length, 3'b000};
            psdu_bits <= {1'b0, length, 3'b000};
            acc       <= '0;
            state     <= ST_DATA_FEED;
          end
        end

        ST_DATA_FEED: begin
          if (accept) begin
            dp_in   <= sym_in;
            dp_run  <= 1'b1;
            gap_cnt <= '0;
            acc     <= acc_next;
            if (acc_next >= need) begin
              beat_cnt <= '0;
              timer    <= '0;
              state    <= ST_DATA_DRAIN;
            end
          end
        end

        ST_DATA_DRAIN: begin
          if (rx_bit_valid) begin
            beat_cnt <= beat_cnt + 16'd1;
            timer    <= '0;
            if (beat_cnt == SERVICE_L + psdu_bits - 16'd1) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else if (timer == DRAIN_TO_L) begin
            state    <= ST_ERROR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ST_DONE:  state <= ST_IDLE;
        ST_ERROR: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_sequencer.sv
// tb_rx_sequencer: directed packets with randomized symbols, SIGNAL gaps and
// descrambler bits, checked against a packet-level model of the sequencer.
// Honors RX_SIGNAL_PARITY_CHECK_EN for the parity-flip packet.
module tb_rx_sequencer;

  localparam int SYM_GAP       = 200;
  localparam int SIG_TIMEOUT   = 1024;
  localparam int DRAIN_TIMEOUT = 4096;
`ifdef RX_SIGNAL_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [51:0] sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic [51:0] dp_in;
  logic        dp_run;
  logic [1:0]  dp_mod;
  logic [1:0]  dp_cr;
  logic        dp_clr;
  logic        sig_bit;
  logic        sig_bit_valid;
  logic        rx_bit;
  logic        rx_bit_valid;
  logic        pld_bit;
  logic        pld_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  rx_sequencer #(
    .SYM_GAP       (SYM_GAP),
    .SIG_TIMEOUT   (SIG_TIMEOUT),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sym_in        (sym_in),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .dp_in         (dp_in),
    .dp_run        (dp_run),
    .dp_mod        (dp_mod),
    .dp_cr         (dp_cr),
    .dp_clr        (dp_clr),
    .sig_bit       (sig_bit),
    .sig_bit_valid (sig_bit_valid),
    .rx_bit        (rx_bit),
    .rx_bit_valid  (rx_bit_valid),
    .pld_bit       (pld_bit),
    .pld_valid     (pld_valid),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitor: free-running counts the main flow snapshots per packet.
  int          cyc = 0;
  int          acc_cnt = 0, run_cnt = 0, done_cnt = 0, err_cnt = 0;
  int          gap_viol = 0, din_bad = 0, prev_run = 0, err_cyc = 0;
  bit          have_prev = 1'b0;
  logic [51:0] last_acc = '0;
  bit          pld_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (sym_valid && sym_ready) begin
        acc_cnt  <= acc_cnt + 1;
        last_acc <= sym_in;
      end
      if (dp_clr) have_prev <= 1'b0;
      if (dp_run) begin
        run_cnt <= run_cnt + 1;
        if (dp_in !== last_acc) din_bad <= din_bad + 1;
        if (have_prev && (cyc - prev_run) < SYM_GAP) gap_viol <= gap_viol + 1;
        prev_run  <= cyc;
        have_prev <= 1'b1;
      end
      if (pld_valid) pld_q.push_back(pld_bit);
      if (done) done_cnt <= done_cnt + 1;
      if (err) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sym_in = 52'({$urandom(), $urandom()});
  endtask

  task automatic recover();
    sym_valid = 1'b0;
    sig_bit_valid = 1'b0;
    rx_bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Rate table from the 802.11a SIGNAL definition; ndbps 0 means invalid.
  function automatic int rate_model(input logic [3:0] r, output logic [1:0] m,
                                    output logic [1:0] c);
    m = 2'b00; c = 2'b00;
    case (r)
      4'b1101: begin m = 2'b00; c = 2'b00; return 24;  end
      4'b1111: begin m = 2'b00; c = 2'b10; return 36;  end
      4'b0101: begin m = 2'b01; c = 2'b00; return 48;  end
      4'b0111: begin m = 2'b01; c = 2'b10; return 72;  end
      4'b1001: begin m = 2'b10; c = 2'b00; return 96;  end
      4'b1011: begin m = 2'b10; c = 2'b10; return 144; end
      4'b0001: begin m = 2'b11; c = 2'b01; return 192; end
      4'b0011: begin m = 2'b11; c = 2'b10; return 216; end
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] rate_at(input int k);
    case (k)
      0: return 4'b1101; 1: return 4'b1111; 2: return 4'b0101; 3: return 4'b0111;
      4: return 4'b1001; 5: return 4'b1011; 6: return 4'b0001; default: return 4'b0011;
    endcase
  endfunction

  task automatic run_packet(input string tag, input logic [3:0] rate, input int len,
                            input bit flip_par, input int sig_beats, input bit stall,
                            input bit rst_drain);
    logic [23:0] b;
    logic [1:0]  emod, ecr, exp_code;
    int          nd, need, nsym, a0, d0, e0, g0, x0, p0, t_run, bad, limit;
    bit          exp_pl[$];
    bit          seen;

    b = '0;
    for (int i = 0; i < 4; i++) b[i] = rate[3-i];
    for (int i = 0; i < 12; i++) b[5+i] = len[i];
    b[17] = (^b[16:0]) ^ flip_par;
    nd   = rate_model(rate, emod, ecr);
    need = 22 + 8 * len;
    nsym = (nd != 0) ? (need + nd - 1) / nd : 0;
    if (sig_beats < 24)              exp_code = 2'b11;
    else if (nd == 0 || len == 0)    exp_code = 2'b01;
    else if (flip_par && PARITY_EN)  exp_code = 2'b10;
    else                             exp_code = 2'b00;

    a0 = acc_cnt; d0 = done_cnt; e0 = err_cnt; g0 = gap_viol; x0 = din_bad;
    p0 = pld_q.size();

    // Packet start and SIGNAL symbol.
    sym_valid = 1'b1;
    seen = 1'b0;
    for (int g = 0; g < 10 && !seen; g++) begin tick(); seen = dp_clr; end
    check({tag, "_dp_clr"}, seen, 1);
    if (!seen) begin recover(); return; end
    check({tag, "_start_mod_cr_code"}, {dp_mod, dp_cr, err_code}, 6'd0);
    seen = 1'b0;
    for (int g = 0; g < 10 && !seen; g++) begin tick(); seen = dp_run; end
    check({tag, "_sig_run"}, seen, 1);
    if (!seen) begin recover(); return; end
    t_run = cyc;

    // SIGNAL bits with random gaps; stray rx beats meanwhile must be ignored.
    for (int i = 0; i < sig_beats; i++) begin
      repeat ($urandom_range(0, 2)) begin
        rx_bit = 1'($urandom_range(0, 1));
        rx_bit_valid = 1'($urandom_range(0, 1));
        tick();
      end
      rx_bit_valid = 1'b0;
      sig_bit = b[i];
      sig_bit_valid = 1'b1;
      tick();
      sig_bit_valid = 1'b0;
    end

    if (exp_code != 2'b00) begin
      limit = (sig_beats < 24) ? SIG_TIMEOUT + 200 : 20;
      for (int g = 0; g < limit && !err; g++) tick();
      seen = err;
      sym_valid = 1'b0;
      check({tag, "_err_pulse"}, seen, 1);
      check({tag, "_err_code"}, err_code, exp_code);
      repeat (3) tick();
      check({tag, "_code_held"}, err_code, exp_code);
      check({tag, "_no_data_sym"}, acc_cnt - a0, 1);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_pulses"}, {done_cnt - d0, err_cnt - e0}, {32'd0, 32'd1});
      if (sig_beats < 24)
        check({tag, "_timeout_window"},
              (err_cyc - t_run >= SIG_TIMEOUT - 1) && (err_cyc - t_run <= SIG_TIMEOUT + 2), 1);
      if (!seen) recover();
      return;
    end

    // DATA symbols, optionally stalling upstream mid-feed.
    for (int g = 0; g < 20000 && (acc_cnt - a0) < 1 + nsym; g++) begin
      tick();
      if (stall && (acc_cnt - a0) == 2) begin
        stall = 1'b0;
        sym_valid = 1'b0;
        repeat (500) tick();
        check({tag, "_stall_no_accept"}, acc_cnt - a0, 2);
        check({tag, "_stall_no_err"}, err_cnt - e0, 0);
        sym_valid = 1'b1;
      end
    end
    check({tag, "_data_syms"}, acc_cnt - a0, 1 + nsym);
    if ((acc_cnt - a0) != 1 + nsym) begin recover(); return; end
    repeat (SYM_GAP + 30) tick();
    sym_valid = 1'b0;
    check({tag, "_no_extra_syms"}, acc_cnt - a0, 1 + nsym);
    check({tag, "_mod_cr"}, {dp_mod, dp_cr}, {emod, ecr});
    check({tag, "_drain_ready_busy"}, {sym_ready, busy}, 2'b01);

    // Descrambler beats: SERVICE, PSDU, then a few trailing ones.
    for (int i = 0; i < 16 + 8 * len + 5; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      rx_bit = 1'($urandom_range(0, 1));
      rx_bit_valid = 1'b1;
      if (i >= 16 && i < 16 + 8 * len) exp_pl.push_back(rx_bit);
      if (rst_drain && i == 20) begin
        rst = 1'b1;
        tick();
        check({tag, "_rst_outputs"},
              {sym_ready, dp_run, dp_mod, dp_cr, dp_clr, pld_valid, pld_bit,
               busy, done, err, err_code}, 15'd0);
        check({tag, "_rst_dp_in"}, dp_in, 0);
        rst = 1'b0;
        rx_bit_valid = 1'b0;
        repeat (5) tick();
        check({tag, "_rst_no_pulse"}, {done_cnt - d0, err_cnt - e0}, 64'd0);
        check({tag, "_rst_idle"}, busy, 0);
        return;
      end
      tick();
      rx_bit_valid = 1'b0;
    end
    repeat (5) tick();

    check({tag, "_pulses"}, {done_cnt - d0, err_cnt - e0}, {32'd1, 32'd0});
    check({tag, "_pld_count"}, pld_q.size() - p0, exp_pl.size());
    bad = 0;
    for (int i = 0; i < exp_pl.size() && p0 + i < pld_q.size(); i++)
      if (pld_q[p0 + i] !== exp_pl[i]) bad++;
    check({tag, "_pld_bits"}, bad, 0);
    check({tag, "_run_spacing"}, gap_viol - g0, 0);
    check({tag, "_dp_in_data"}, din_bad - x0, 0);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    sym_in = '0; sym_valid = 1'b0;
    sig_bit = 1'b0; sig_bit_valid = 1'b0;
    rx_bit = 1'b0; rx_bit_valid = 1'b0;
    tick();
    tick();
    check("reset_outputs",
          {sym_ready, dp_run, dp_mod, dp_cr, dp_clr, pld_valid, pld_bit,
           busy, done, err, err_code}, 15'd0);
    check("reset_dp_in", dp_in, 0);
    rst = 1'b0;
    tick();

    // Stray bit valids while idle must not produce payload or leave IDLE.
    rx_bit = 1'b1; rx_bit_valid = 1'b1; sig_bit = 1'b1; sig_bit_valid = 1'b1;
    repeat (10) tick();
    rx_bit_valid = 1'b0; sig_bit_valid = 1'b0;
    check("idle_stray_bits", {pld_q.size(), 31'd0, busy}, 64'd0);

    run_packet("b12_len1",    4'b1101, 1,   1'b0, 24, 1'b0, 1'b0);
    run_packet("q64_len100",  4'b0011, 100, 1'b0, 24, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++)
      run_packet("random", rate_at($urandom_range(0, 7)), $urandom_range(1, 40),
                 1'b0, 24, 1'b0, 1'b0);
    run_packet("bad_rate",    4'b0000, 5,   1'b0, 24, 1'b0, 1'b0);
    run_packet("len_zero",    4'b1101, 0,   1'b0, 24, 1'b0, 1'b0);
    run_packet("parity_flip", 4'b0101, 3,   1'b1, 24, 1'b0, 1'b0);
    run_packet("stall",       4'b0101, 20,  1'b0, 24, 1'b1, 1'b0);
    run_packet("sig_timeout", 4'b1101, 4,   1'b0, 20, 1'b0, 1'b0);
    run_packet("rst_drain",   4'b1011, 10,  1'b0, 24, 1'b0, 1'b1);
    run_packet("after_rst",   4'b0111, 6,   1'b0, 24, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
